// File: rtl/regfile_pkg.sv
// Shared sizing constants for the bypassed architectural register file.
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_bypassed_reg_en_srst.sv
// Single storage register with write enable and synchronous active-low reset.
module reg_en_srst
  import regfile_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/regfile_bypassed.sv
// 32x32 register file, r0 hardwired to zero, with same-cycle write-through
// forwarding on both read ports, a registered debug port and a commit counter.
module regfile_bypassed
  import regfile_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  input  logic [ADDR_W-1:0] dbg_readReg,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  commit_count
);

  logic [NUM_REGS-1:0]             wr_onehot;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic                            write_accept;
  logic                            bypass_a;
  logic                            bypass_b;
  logic [DATA_W-1:0]               dbg_data_reg;
  logic [CNT_W-1:0]                commit_count_reg;

  // Reset and enable gate the decode, so a write during reset never lands.
  always_comb begin
    wr_onehot = '0;
    if (reset && ctrl_writeEnable) begin
      wr_onehot[ctrl_writeReg] = 1'b1;
    end
    wr_onehot[0] = 1'b0;
  end

  assign write_accept = |wr_onehot;

  assign regs[0] = '0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      reg_en_srst #(.W(DATA_W)) u_reg (
        .clock (clock),
        .reset (reset),
        .en    (wr_onehot[gi]),
        .d     (data_writeReg),
        .q     (regs[gi])
      );
    end
  endgenerate

  // Bypass only for a live, non-r0 write; r0 reads fall through to regs[0]=0.
  assign bypass_a = reset && ctrl_writeEnable && (ctrl_writeReg != REG_ZERO)
                    && (ctrl_readRegA == ctrl_writeReg);
  assign bypass_b = reset && ctrl_writeEnable && (ctrl_writeReg != REG_ZERO)
                    && (ctrl_readRegB == ctrl_writeReg);

  assign data_readRegA = bypass_a ? data_writeReg : regs[ctrl_readRegA];
  assign data_readRegB = bypass_b ? data_writeReg : regs[ctrl_readRegB];

  always_ff @(posedge clock) begin
    if (!reset) begin
      dbg_data_reg     <= '0;
      commit_count_reg <= '0;
    end else begin
      dbg_data_reg <= regs[dbg_readReg];
      if (write_accept) begin
        commit_count_reg <= commit_count_reg + CNT_W'(1);
      end
    end
  end

  assign dbg_data     = dbg_data_reg;
  assign commit_count = commit_count_reg;

endmodule

// File: tb/tb_regfile_bypassed.sv
// Directed plus randomized bench for regfile_bypassed against an array-based model.
module tb_regfile_bypassed;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic [4:0]  dbg_readReg;
  logic [31:0] dbg_data;
  logic [31:0] commit_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_dbg;
  logic [31:0] m_count;

  regfile_bypassed dut (
    .clock            (clock),
    .reset            (reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .dbg_readReg      (dbg_readReg),
    .dbg_data         (dbg_data),
    .commit_count     (commit_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (reset && ctrl_writeEnable && idx == ctrl_writeReg) return data_writeReg;
    return m_regs[idx];
  endfunction

  // Apply one cycle: drive after the falling edge, check, then advance the model.
  task automatic step(input logic rst, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd, input logic [4:0] ra,
                      input logic [4:0] rb, input logic [4:0] dr);
    @(negedge clock);
    reset = rst; ctrl_writeEnable = we; ctrl_writeReg = wr; data_writeReg = wd;
    ctrl_readRegA = ra; ctrl_readRegB = rb; dbg_readReg = dr;
    #1;
    check("read_a", data_readRegA, exp_read(ra));
    check("read_b", data_readRegB, exp_read(rb));
    check("dbg", dbg_data, m_dbg);
    check("count", commit_count, m_count);
    $display("step rst=%0b we=%0b wr=%0d wd=%08h ra=%0d a=%08h rb=%0d b=%08h dbg=%08h cnt=%0d",
             rst, we, wr, wd, ra, data_readRegA, rb, data_readRegB, dbg_data, commit_count);
    @(posedge clock);
    if (!rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_dbg = 32'h0;
      m_count = 32'h0;
    end else begin
      m_dbg = (dr == 5'd0) ? 32'h0 : m_regs[dr];
      if (we && wr != 5'd0) begin
        m_regs[wr] = wd;
        m_count = m_count + 32'd1;
      end
    end
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    m_dbg = 32'h0;
    m_count = 32'h0;
    reset = 1'b0; ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
    ctrl_readRegA = '0; ctrl_readRegB = '0; dbg_readReg = '0;

    // Random writes, then two reset edges; everything must read back zero.
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd3);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd5, 5'd6);
    for (int i = 0; i < 32; i++)
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));
    check("reset_count_zero", commit_count, 32'h0);

    // Basic write then read on both ports.
    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd0);
    check("basic_a", data_readRegA, 32'hDEADBEEF);
    check("basic_count", commit_count, 32'd1);

    // Same-cycle forwarding on A while B reads an older value.
    step(1'b1, 1'b1, 5'd3, 32'h55, 5'd0, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd7, 32'h1234, 5'd7, 5'd3, 5'd0);
    check("fwd_a", data_readRegA, 32'h1234);
    check("fwd_b", data_readRegB, 32'h55);
    step(1'b1, 1'b1, 5'd7, 32'hCAFE, 5'd7, 5'd7, 5'd7);
    check("fwd_ab_same", data_readRegB, 32'hCAFE);

    // r0 write is dropped; sweep all registers afterwards.
    step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    check("r0_fwd_a", data_readRegA, 32'h0);
    for (int i = 0; i < 32; i++)
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i), 5'(i));

    // Reset with a concurrent write to r9.
    step(1'b1, 1'b1, 5'd9, 32'h77, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd9, 32'hAB, 5'd9, 5'd9, 5'd9);
    check("rst_no_fwd", data_readRegA, 32'h77);
    step(1'b0, 1'b1, 5'd9, 32'hAB, 5'd9, 5'd9, 5'd9);
    check("rst_a_zero", data_readRegA, 32'h0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);
    check("rst_r9_zero", data_readRegA, 32'h0);

    // Debug port latency on r31.
    step(1'b1, 1'b1, 5'd31, 32'h80000000, 5'd0, 5'd0, 5'd31);
    check("dbg_no_fwd", dbg_data, 32'h0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd31);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    check("dbg_r31", dbg_data, 32'h80000000);

    // Randomized traffic with occasional resets and address collisions.
    for (int i = 0; i < 400; i++) begin
      logic        rst;
      logic        we;
      logic [4:0]  wr;
      logic [4:0]  ra;
      logic [4:0]  rb;
      rst = ($urandom_range(0, 29) != 0);
      we  = $urandom_range(0, 1) == 1;
      wr  = 5'($urandom_range(0, 31));
      ra  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      rb  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      step(rst, we, wr, $urandom, ra, rb, 5'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
